// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: request-side controller for the 64-bit combinational ALU.
// Requests are registered into a single issue slot that drives the ALU.
// One edge later the ALU result is captured into a small response FIFO.
// The FIFO is drained over a tagged valid/ready response stream.

module alu_issue_ctrl #(
    parameter int DW    = 64,
    parameter int TAGW  = 4,
    parameter int DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [DW-1:0]   req_a,
    input  logic [DW-1:0]   req_b,
    input  logic [TAGW-1:0] req_tag,

    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [3:0]      alu_op,
    input  logic [DW-1:0]   alu_out,
    input  logic            alu_slt,
    input  logic            alu_sltu,
    input  logic            alu_beq,
    input  logic            alu_bne,
    input  logic            alu_grt,
    input  logic            alu_grtu,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic [5:0]      rsp_flags,
    output logic [TAGW-1:0] rsp_tag,
    output logic            rsp_err,

    output logic [31:0]     cnt_done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = DEPTH[CW:0];
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } slot_state_t;

    slot_state_t     r_state;
    slot_state_t     w_state_next;
    logic            w_iv;

    logic [3:0]      r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [TAGW-1:0] r_tag;

    logic [DW-1:0]   r_mem_data  [DEPTH];
    logic [5:0]      r_mem_flags [DEPTH];
    logic [TAGW-1:0] r_mem_tag   [DEPTH];
    logic            r_mem_err   [DEPTH];

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            r_req_ready;
    logic            w_ready_next;
    logic [31:0]     r_cnt_done;

    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_rsp_valid;
    logic            w_illegal;
    logic [DW-1:0]   w_push_data;
    logic [5:0]      w_push_flags;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign w_fire      = req_valid & r_req_ready;
    assign w_push      = w_iv;
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid & rsp_ready;

    // Illegal opcodes return zero data/flags so garbage from the ALU never leaks out.
    assign w_illegal    = (r_op > 4'd9);
    assign w_push_data  = w_illegal ? '0 : alu_out;
    assign w_push_flags = (r_op <= 4'd1) ?
                          {alu_grtu, alu_grt, alu_bne, alu_beq, alu_sltu, alu_slt} : 6'b0;

    // Issue slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An occupied slot always executes this edge, so it stays busy only if refilled.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = w_fire ? EXEC : IDLE;
            EXEC:    w_state_next = w_fire ? EXEC : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Slot-valid flag decoded from the state.
    always_comb begin
        w_iv = 1'b0;
        if (r_state == EXEC) begin
            w_iv = 1'b1;
        end
    end

    // Issue payload register; it holds its last contents while the slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_tag <= '0;
        end else if (w_fire) begin
            r_op  <= req_op;
            r_a   <= req_a;
            r_b   <= req_b;
            r_tag <= req_tag;
        end
    end

    // Next FIFO occupancy and the ready decision, which counts the issue slot too.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
        w_ready_next = (({1'b0, w_count_next} + {{CW{1'b0}}, (w_state_next == EXEC)}) < DEPTH_C);
    end

    // Response FIFO storage, cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i]  <= '0;
                r_mem_flags[i] <= '0;
                r_mem_tag[i]   <= '0;
                r_mem_err[i]   <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_data[r_wr_ptr]  <= w_push_data;
            r_mem_flags[r_wr_ptr] <= w_push_flags;
            r_mem_tag[r_wr_ptr]   <= r_tag;
            r_mem_err[r_wr_ptr]   <= w_illegal;
        end
    end

    // FIFO pointers, occupancy, registered ready and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b0;
            r_cnt_done  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptrInc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr   <= ptrInc(r_rd_ptr);
                r_cnt_done <= r_cnt_done + 32'd1;
            end
            r_count     <= w_count_next;
            r_req_ready <= w_ready_next;
        end
    end

    assign req_ready = r_req_ready;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign rsp_valid = w_rsp_valid;
    assign rsp_data  = r_mem_data[r_rd_ptr];
    assign rsp_flags = r_mem_flags[r_rd_ptr];
    assign rsp_tag   = r_mem_tag[r_rd_ptr];
    assign rsp_err   = r_mem_err[r_rd_ptr];
    assign cnt_done  = r_cnt_done;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a behavioural ALU closes the loop, directed
// requests push hand-computed responses into a scoreboard queue, and a
// negedge monitor pops and compares whenever a response is accepted.

module tb_alu_issue_ctrl;

    localparam int DW    = 64;
    localparam int TAGW  = 4;
    localparam int DEPTH = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic [DW-1:0]   req_a;
    logic [DW-1:0]   req_b;
    logic [TAGW-1:0] req_tag;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [3:0]      alu_op;
    logic [DW-1:0]   alu_out;
    logic            alu_slt, alu_sltu, alu_beq, alu_bne, alu_grt, alu_grtu;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [5:0]      rsp_flags;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_err;
    logic [31:0]     cnt_done;

    typedef struct packed {
        logic [63:0] data;
        logic [5:0]  flags;
        logic [3:0]  tag;
        logic        err;
    } rsp_t;

    rsp_t expQ[$];
    int   popCycles[$];
    logic recordPops = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;

    alu_issue_ctrl #(.DW(DW), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_slt   (alu_slt),
        .alu_sltu  (alu_sltu),
        .alu_beq   (alu_beq),
        .alu_bne   (alu_bne),
        .alu_grt   (alu_grt),
        .alu_grtu  (alu_grtu),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .cnt_done  (cnt_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Behavioural ALU; illegal opcodes produce nonzero junk so masking is visible.
    always_comb begin
        alu_slt  = ($signed(alu_a) < $signed(alu_b));
        alu_sltu = (alu_a < alu_b);
        alu_beq  = (alu_a == alu_b);
        alu_bne  = (alu_a != alu_b);
        alu_grt  = ($signed(alu_a) > $signed(alu_b));
        alu_grtu = (alu_a > alu_b);
        case (alu_op)
            4'd0:    alu_out = alu_a + alu_b;
            4'd1:    alu_out = alu_a - alu_b;
            4'd2:    alu_out = alu_a & alu_b;
            4'd3:    alu_out = alu_a | alu_b;
            4'd4:    alu_out = alu_a ^ alu_b;
            4'd5:    alu_out = alu_a << alu_b[5:0];
            4'd6:    alu_out = alu_a >> alu_b[5:0];
            4'd7:    alu_out = $unsigned($signed(alu_a) >>> alu_b[5:0]);
            4'd8:    alu_out = {63'b0, alu_slt};
            4'd9:    alu_out = {63'b0, alu_sltu};
            default: alu_out = ~alu_a | 64'h1;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request and hold it until it fires; call at posedge+1.
    task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] tag, input logic [63:0] eData,
                                 input logic [5:0] eFlags, input logic eErr, output int stalls);
        rsp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        stalls    = 0;
        @(negedge clk);
        while (!req_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_accept_timeout: tag %0d never accepted, req_ready=%0b required 1", tag, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.data  = eData;
        e.flags = eFlags;
        e.tag   = tag;
        e.err   = eErr;
        expQ.push_back(e);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait for every expected response to be consumed, then settle after the last pop.
    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", expQ.size());
            expQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    rsp_t monE;
    rsp_t holdRsp;
    logic holdValid = 1'b0;

    // Monitor: compare accepted responses in order and check stability under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid) begin
                checkOutput("hold_valid", {63'b0, rsp_valid}, 64'd1);
                checkOutput("hold_data", rsp_data, holdRsp.data);
                checkOutput("hold_tag", {60'b0, rsp_tag}, {60'b0, holdRsp.tag});
            end
            if (rsp_valid && rsp_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: tag %0d data 0x%0h, required no response", rsp_tag, rsp_data);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("rsp_data", rsp_data, monE.data);
                    checkOutput("rsp_flags", {58'b0, rsp_flags}, {58'b0, monE.flags});
                    checkOutput("rsp_tag", {60'b0, rsp_tag}, {60'b0, monE.tag});
                    checkOutput("rsp_err", {63'b0, rsp_err}, {63'b0, monE.err});
                    if (recordPops) popCycles.push_back(cycle);
                end
            end
            holdValid = rsp_valid && !rsp_ready;
            holdRsp.data = rsp_data;
            holdRsp.tag  = rsp_tag;
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    int st;
    int stallTotal;
    int readyHigh;
    int pre;

    // Directed test sequence.
    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;

        #12;
        checkOutput("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        checkOutput("reset_rsp_data", rsp_data, 64'd0);
        checkOutput("reset_rsp_flags", {58'b0, rsp_flags}, 64'd0);
        checkOutput("reset_rsp_tag_err", {59'b0, rsp_tag, rsp_err}, 64'd0);
        checkOutput("reset_alu_a", alu_a, 64'd0);
        checkOutput("reset_alu_b", alu_b, 64'd0);
        checkOutput("reset_alu_op", {60'b0, alu_op}, 64'd0);
        checkOutput("reset_cnt_done", {32'b0, cnt_done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", {63'b0, req_ready}, 64'd1);

        // add 5+7, with latency check
        applyStimulus(4'd0, 64'd5, 64'd7, 4'd3, 64'd12, 6'b001011, 1'b0, st);
        @(negedge clk);
        checkOutput("latency_not_yet", {63'b0, rsp_valid}, 64'd0);
        @(negedge clk);
        checkOutput("latency_valid", {63'b0, rsp_valid}, 64'd1);
        waitDrain();
        checkOutput("cnt_done_1", {32'b0, cnt_done}, 64'd1);

        // sub equal operands, then xor
        applyStimulus(4'd1, 64'd9, 64'd9, 4'd1, 64'd0, 6'b000100, 1'b0, st);
        applyStimulus(4'd4, 64'hF0, 64'hFF, 4'd2, 64'h0F, 6'b000000, 1'b0, st);
        waitDrain();
        checkOutput("cnt_done_3", {32'b0, cnt_done}, 64'd3);

        // illegal opcode
        applyStimulus(4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5,
                      64'd0, 6'b000000, 1'b1, st);
        waitDrain();
        checkOutput("cnt_done_4", {32'b0, cnt_done}, 64'd4);

        // back-to-back adds, one per cycle
        popCycles.delete();
        recordPops = 1'b1;
        stallTotal = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'd0, 64'(100 + k), 64'(k), 4'(k), 64'(100 + 2 * k), 6'b111000, 1'b0, st);
            stallTotal += st;
        end
        waitDrain();
        recordPops = 1'b0;
        checkOutput("b2b_no_stalls", 64'(stallTotal), 64'd0);
        checkOutput("b2b_pop_count", 64'(popCycles.size()), 64'd8);
        if (popCycles.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                checkOutput("b2b_consecutive", 64'(popCycles[i] - popCycles[i-1]), 64'd1);
            end
        end
        checkOutput("cnt_done_12", {32'b0, cnt_done}, 64'd12);

        // backpressure: three accepted, fourth held off
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'd1, 64'd10, 64'(k), 4'(8 + k), 64'(10 - k), 6'b111000, 1'b0, st);
            checkOutput("bp_accept_no_stall", 64'(st), 64'd0);
        end
        req_valid = 1'b1;
        req_op    = 4'd1;
        req_a     = 64'd10;
        req_b     = 64'd3;
        req_tag   = 4'd11;
        readyHigh = 0;
        repeat (4) begin
            @(negedge clk);
            if (req_ready) readyHigh++;
        end
        checkOutput("bp_ready_low", 64'(readyHigh), 64'd0);
        checkOutput("bp_head_valid", {63'b0, rsp_valid}, 64'd1);
        checkOutput("bp_head_tag", {60'b0, rsp_tag}, 64'd8);
        checkOutput("bp_head_data", rsp_data, 64'd10);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        applyStimulus(4'd1, 64'd10, 64'd3, 4'd11, 64'd7, 6'b111000, 1'b0, st);
        applyStimulus(4'd1, 64'd10, 64'd4, 4'd12, 64'd6, 6'b111000, 1'b0, st);
        waitDrain();
        checkOutput("cnt_done_17", {32'b0, cnt_done}, 64'd17);

        // asynchronous reset with two responses queued
        rsp_ready = 1'b0;
        applyStimulus(4'd0, 64'd1, 64'd1, 4'd1, 64'd2, 6'b000100, 1'b0, st);
        applyStimulus(4'd0, 64'd1, 64'd1, 4'd2, 64'd2, 6'b000100, 1'b0, st);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", {63'b0, rsp_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        expQ.delete();
        checkOutput("midreset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        checkOutput("midreset_cnt_done", {32'b0, cnt_done}, 64'd0);
        checkOutput("midreset_rsp_data", rsp_data, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        pre = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) pre++;
        end
        checkOutput("no_stale_rsp", 64'(pre), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd15, 64'd0, 6'b101001, 1'b0, st);
        waitDrain();
        checkOutput("cnt_done_after_reset", {32'b0, cnt_done}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
